// File: rtl/adc_avg_filter_if.sv
// Valid-qualified sample stream: used for raw ADC samples in and block averages out.
interface adc_avg_filter_if #(
    parameter int unsigned WIDTH = 12
);
    logic             valid;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data);
    modport slave  (input  valid, input  data);
endinterface

// File: rtl/adc_avg_filter.sv
// Block-average decimator: sums 2^L valid ADC samples and emits one rounded
// (half-up) average per block as a single-cycle valid pulse.
module adc_avg_filter #(
    parameter int unsigned ADC_WIDTH    = 12,
    parameter int unsigned MAX_LOG2_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  param_wen_i,
    input  logic [31:0]           avg_log2_len_i,
    input  logic                  avg_en_i,
    adc_avg_filter_if.slave       sample_if,
    adc_avg_filter_if.master      avg_if,
    output logic [31:0]           avg_count_o
);
    localparam int unsigned ACC_W = ADC_WIDTH + MAX_LOG2_LEN;
    localparam int unsigned LEN_W = $clog2(MAX_LOG2_LEN + 1);
    localparam int unsigned CNT_W = MAX_LOG2_LEN;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DUMP  = 2'd2;

    logic [1:0]           state_q,     state_d;
    logic [LEN_W-1:0]     len_q,       len_d;
    logic [ACC_W-1:0]     acc_q,       acc_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [ACC_W-1:0]     final_sum_q, final_sum_d;
    logic                 avg_valid_q, avg_valid_d;
    logic [ADC_WIDTH-1:0] avg_data_q,  avg_data_d;
    logic [31:0]          avg_count_q, avg_count_d;

    logic [LEN_W-1:0]     len_clamp_c;
    logic [CNT_W:0]       blk_len_c;
    logic [CNT_W-1:0]     cnt_last_c;
    logic                 cnt_full_c;
    logic [ACC_W-1:0]     round_c;
    logic [ACC_W-1:0]     avg_full_c;
    logic [ACC_W-1:0]     sample_ext_c;

    // Requested lengths above the accumulator's headroom saturate to the max.
    assign len_clamp_c  = (avg_log2_len_i > 32'(MAX_LOG2_LEN)) ? LEN_W'(MAX_LOG2_LEN)
                                                               : LEN_W'(avg_log2_len_i);
    assign blk_len_c    = (CNT_W + 1)'(1) << len_q;
    assign cnt_last_c   = CNT_W'(blk_len_c - (CNT_W + 1)'(1));
    assign cnt_full_c   = (cnt_q == cnt_last_c);
    assign sample_ext_c = ACC_W'(sample_if.data);

    // Half-up rounding: add half an LSB of the shifted result before the shift.
    assign round_c    = (len_q == '0) ? '0 : (ACC_W'(1) << (len_q - LEN_W'(1)));
    assign avg_full_c = (final_sum_q + round_c) >> len_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        final_sum_d = final_sum_q;
        avg_valid_d = 1'b0;
        avg_data_d  = avg_data_q;
        avg_count_d = avg_count_q;

        // DUMP always publishes, regardless of enable or parameter writes.
        if (state_q == DUMP) begin
            avg_valid_d = 1'b1;
            avg_data_d  = ADC_WIDTH'(avg_full_c);
            avg_count_d = avg_count_q + 32'd1;
        end

        if (param_wen_i) begin
            len_d   = len_clamp_c;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = avg_en_i ? ACCUM : IDLE;
        end else if (!avg_en_i) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
                ACCUM: begin
                    if (sample_if.valid) begin
                        if (cnt_full_c) begin
                            final_sum_d = acc_q + sample_ext_c;
                            acc_d       = '0;
                            cnt_d       = '0;
                            state_d     = DUMP;
                        end else begin
                            acc_d = acc_q + sample_ext_c;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DUMP: begin
                    if (sample_if.valid) begin
                        if (len_q == '0) begin
                            final_sum_d = sample_ext_c;
                            state_d     = DUMP;
                        end else begin
                            acc_d   = sample_ext_c;
                            cnt_d   = CNT_W'(1);
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                default: begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            final_sum_q <= '0;
            avg_valid_q <= 1'b0;
            avg_data_q  <= '0;
            avg_count_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            final_sum_q <= final_sum_d;
            avg_valid_q <= avg_valid_d;
            avg_data_q  <= avg_data_d;
            avg_count_q <= avg_count_d;
        end
    end

    assign avg_if.valid = avg_valid_q;
    assign avg_if.data  = avg_data_q;
    assign avg_count_o  = avg_count_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed vector bench for adc_avg_filter: per-cycle stimulus rows with
// hand-computed expected outputs, plus a bounded-wait latency sequence.
module tb_adc_avg_filter;
    localparam int unsigned W = 12;

    typedef struct {
        logic         rst;
        logic         wen;
        logic [31:0]  len;
        logic         en;
        logic         vld;
        logic [W-1:0] data;
        logic         ev;
        logic [W-1:0] ed;
        logic [31:0]  ec;
        string        name;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        param_wen;
    logic [31:0] avg_log2_len;
    logic        avg_en;
    logic [31:0] avg_count;

    adc_avg_filter_if #(.WIDTH(W)) s_if ();
    adc_avg_filter_if #(.WIDTH(W)) a_if ();

    adc_avg_filter #(.ADC_WIDTH(W), .MAX_LOG2_LEN(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .param_wen_i    (param_wen),
        .avg_log2_len_i (avg_log2_len),
        .avg_en_i       (avg_en),
        .sample_if      (s_if.slave),
        .avg_if         (a_if.master),
        .avg_count_o    (avg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic add(input string nm, input logic r, input logic w, input logic [31:0] l,
                       input logic e, input logic v, input logic [W-1:0] d,
                       input logic ev, input logic [W-1:0] ed, input logic [31:0] ec);
        vec_t t;
        t.name = nm; t.rst = r; t.wen = w; t.len = l; t.en = e; t.vld = v; t.data = d;
        t.ev = ev; t.ed = ed; t.ec = ec;
        vq.push_back(t);
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] l,
                         input logic e, input logic v, input logic [W-1:0] d);
        rst = r; param_wen = w; avg_log2_len = l; avg_en = e;
        s_if.valid = v; s_if.data = d;
    endtask

    task automatic check(input string nm, input logic ev, input logic [W-1:0] ed,
                         input logic [31:0] ec);
        n_vec++;
        if (a_if.valid !== ev || a_if.data !== ed || avg_count !== ec) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b data=%0d count=%0d, expected valid=%0b data=%0d count=%0d",
                     nm, a_if.valid, a_if.data, avg_count, ev, ed, ec);
        end
    endtask

    initial begin
        int  k;
        bit  seen;

        // Reset held with sample_valid toggling, then idle with avg_en low.
        for (int i = 0; i < 3; i++) add("reset", 1, 0, 0, 0, 1'(i), 12'd77, 0, 0, 0);
        for (int i = 0; i < 10; i++) add("idle_en0", 0, 0, 0, 0, 1'(i), 12'd99, 0, 0, 0);

        // L=2 block of 100..103: output two edges after the last sample.
        add("l2_cfg", 0, 1, 2, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add("l2_smp", 0, 0, 0, 1, 1, W'(100 + i), 0, 0, 0);
        add("l2_out", 0, 0, 0, 1, 0, 0, 1, 12'd102, 1);
        add("l2_hold", 0, 0, 0, 1, 0, 0, 0, 12'd102, 1);

        // L=0 passthrough, back-to-back.
        add("l0_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("l0_cfg", 0, 1, 0, 1, 0, 0, 0, 0, 0);
        add("l0_s5", 0, 0, 0, 1, 1, 12'd5, 0, 0, 0);
        add("l0_s4095", 0, 0, 0, 1, 1, 12'd4095, 1, 12'd5, 1);
        add("l0_s0", 0, 0, 0, 1, 1, 12'd0, 1, 12'd4095, 2);
        add("l0_out3", 0, 0, 0, 1, 0, 0, 1, 12'd0, 3);
        add("l0_hold", 0, 0, 0, 1, 0, 0, 0, 12'd0, 3);

        // Length 20 clamps to 8; 256 full-scale samples -> 4095.
        add("fs_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("fs_cfg", 0, 1, 20, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) add("fs_smp", 0, 0, 0, 1, 1, 12'd4095, 0, 0, 0);
        add("fs_out", 0, 0, 0, 1, 0, 0, 1, 12'd4095, 1);
        add("fs_hold", 0, 0, 0, 1, 0, 0, 0, 12'd4095, 1);

        // Mid-block L change discards partial sum and the coincident sample.
        add("mid_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("mid_cfg", 0, 1, 3, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add("mid_smp", 0, 0, 0, 1, 1, 12'd1000, 0, 0, 0);
        add("mid_wen", 0, 1, 1, 1, 1, 12'd4000, 0, 0, 0);
        add("mid_s10", 0, 0, 0, 1, 1, 12'd10, 0, 0, 0);
        add("mid_s11", 0, 0, 0, 1, 1, 12'd11, 0, 0, 0);
        add("mid_out", 0, 0, 0, 1, 0, 0, 1, 12'd11, 1);
        add("mid_hold", 0, 0, 0, 1, 0, 0, 0, 12'd11, 1);

        // Parameter write during DUMP: pending output uses the old length.
        add("dw_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("dw_cfg", 0, 1, 1, 1, 0, 0, 0, 0, 0);
        add("dw_s6", 0, 0, 0, 1, 1, 12'd6, 0, 0, 0);
        add("dw_s7", 0, 0, 0, 1, 1, 12'd7, 0, 0, 0);
        add("dw_wen", 0, 1, 0, 1, 0, 0, 1, 12'd7, 1);
        add("dw_s9", 0, 0, 0, 1, 1, 12'd9, 0, 12'd7, 1);
        add("dw_out", 0, 0, 0, 1, 0, 0, 1, 12'd9, 2);

        // Enable drop mid-block clears partial sum; IDLE ignores samples.
        add("en_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("en_cfg", 0, 1, 2, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add("en_smp", 0, 0, 0, 1, 1, 12'd50, 0, 0, 0);
        add("en_low", 0, 0, 0, 0, 1, 12'd50, 0, 0, 0);
        add("en_idle", 0, 0, 0, 1, 1, 12'd999, 0, 0, 0);
        for (int i = 0; i < 4; i++) add("en_s8", 0, 0, 0, 1, 1, 12'd8, 0, 0, 0);
        add("en_out", 0, 0, 0, 1, 0, 0, 1, 12'd8, 1);
        add("en_hold", 0, 0, 0, 1, 0, 0, 0, 12'd8, 1);

        // Same with rst mid-block: count and data restart from 0.
        add("rb_cfg", 0, 1, 2, 1, 0, 0, 0, 12'd8, 1);
        for (int i = 0; i < 3; i++) add("rb_smp", 0, 0, 0, 1, 1, 12'd50, 0, 12'd8, 1);
        add("rb_rst", 1, 0, 0, 1, 1, 12'd50, 0, 0, 0);
        add("rb_cfg2", 0, 1, 2, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add("rb_s8", 0, 0, 0, 1, 1, 12'd8, 0, 0, 0);
        add("rb_out", 0, 0, 0, 1, 0, 0, 1, 12'd8, 1);
        add("rb_hold", 0, 0, 0, 1, 0, 0, 0, 12'd8, 1);

        drive(1, 0, 0, 0, 0, 0);
        #1;
        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].wen, vq[i].len, vq[i].en, vq[i].vld, vq[i].data);
            @(posedge clk);
            #1;
            check(vq[i].name, vq[i].ev, vq[i].ed, vq[i].ec);
        end

        // L=3 with samples 1..8: sum 36, (36+4)>>3 = 5, exactly one pulse.
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 1, 3, 1, 0, 0);
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 0, 1, 1, W'(i));
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 1, 0, 0);
        seen = 0;
        k = 0;
        while (!seen && k < 6) begin
            @(posedge clk); #1;
            if (a_if.valid === 1'b1) seen = 1;
            else k++;
        end
        n_vec++;
        if (!seen || k != 0) begin
            n_fail++;
            $display("FAIL seq_latency: got pulse=%0b after %0d extra cycles, expected pulse after 0", seen, k);
        end
        n_vec++;
        if (a_if.data !== 12'd5 || avg_count !== 32'd1) begin
            n_fail++;
            $display("FAIL seq_value: got data=%0d count=%0d, expected data=5 count=1", a_if.data, avg_count);
        end
        @(posedge clk); #1;
        check("seq_single_pulse", 0, 12'd5, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_avg_filter.md
Name: adc_avg_filter

Overview:
Block-average decimator placed directly upstream of the ADC-to-DDS mapping core. It takes raw ADC samples qualified by a valid strobe and sums a block of 2^L samples. It then emits one rounded average per block, with a one-cycle valid pulse. The mapping stage consumes a noise-reduced, decimated sample instead of raw conversions.

Parameters:
ADC_WIDTH, 12, sample and average width in bits
MAX_LOG2_LEN, 8, largest supported log2 block length; accumulator width is ADC_WIDTH+MAX_LOG2_LEN

Ports:
clk  input  1  single clock; ADC samples are already synchronous to it
rst  input  1  synchronous, active-high reset
param_wen  input  1  latch avg_log2_len on this cycle
avg_log2_len  input  32  requested L (block = 2^L samples)
avg_en  input  1  enable; low = idle and clear partial block
sample_valid  input  1  sample_data valid this cycle
sample_data  input  ADC_WIDTH  unsigned raw ADC code
avg_valid  output  1  one-cycle pulse, avg_data updated
avg_data  output  ADC_WIDTH  rounded block average
avg_count  output  32  number of averages produced, wraps at 2^32

Behaviour:
- Reset (rst=1 at edge): len_buf=0, acc=0, cnt=0, final_sum=0, state=IDLE, avg_valid=0, avg_data=0, avg_count=0. rst has priority over every other input.
- Parameter latch on param_wen:
  - len_buf <= min(avg_log2_len, MAX_LOG2_LEN); any value above MAX_LOG2_LEN clamps to it.
  - The same edge discards any partial block: acc=0, cnt=0, state=ACCUM if avg_en else IDLE.
  - A pending DUMP still completes and produces its output.
  - A sample presented in the same cycle as param_wen is dropped.
- States: IDLE, ACCUM, DUMP.
- IDLE:
  - Entered when avg_en=0 from any state, except that DUMP always finishes its output first.
  - acc and cnt are held at 0 and samples are ignored.
  - avg_data holds its last value; avg_valid=0.
  - avg_en=1 -> ACCUM next cycle.
- ACCUM, on sample_valid:
  - If cnt == 2^len_buf - 1: final_sum <= acc + sample_data, acc <= 0, cnt <= 0, state <= DUMP.
  - Otherwise: acc <= acc + sample_data, cnt <= cnt + 1.
  - With no sample_valid, all registers hold.
- DUMP (exactly one cycle):
  - avg_data <= (final_sum + R) >> len_buf, where R = 2^(len_buf-1) for len_buf > 0 and R = 0 for len_buf = 0; rounding is half-up.
  - avg_valid <= 1 for one cycle; avg_count <= avg_count + 1.
  - A sample_valid in DUMP is the first sample of the next block.
    - If it completes a block on its own (len_buf=0): final_sum <= sample_data and the state stays DUMP.
    - Otherwise: acc <= sample_data, cnt <= 1, state <= ACCUM.
    - If avg_en=0, the sample is dropped and the next state is IDLE.
  - With no sample in DUMP: next state is ACCUM if avg_en, else IDLE.
- Latency: last sample of a block presented in cycle c -> DUMP in cycle c+1 -> avg_valid=1 with the new avg_data in cycle c+2.
- Throughput: one sample per cycle with no bubbles, including len_buf=0 (back-to-back averages).
- Width: acc and final_sum are ADC_WIDTH+MAX_LOG2_LEN bits unsigned.
  - Worst case 2^L*(2^W-1) + 2^(L-1) < 2^(W+L), so the sum cannot overflow.
  - The result is at most 2^W-1, so no saturation logic is needed.
- avg_valid is never high for two consecutive cycles unless len_buf=0 with consecutive samples.

Test Plan:
- Reset: assert rst for 3 cycles with sample_valid toggling -> avg_valid=0, avg_data=0, avg_count=0; no output for 10 cycles after release with avg_en=0.
- Block average and latency: L=2, samples 100,101,102,103 in cycles 0-3 -> avg_valid only in cycle 5, avg_data=102 ((406+2)>>2), avg_count=1.
- Passthrough and throughput: L=0, samples 5,4095,0 back-to-back in cycles 0-2 -> avg_valid in cycles 2,3,4 with avg_data 5,4095,0; avg_count=3.
- Full-scale and clamp: avg_log2_len=20 (clamps to 8), 256 samples of 4095 -> one output, 4095, after exactly the 256th sample; 255 samples produce no output.
- Mid-block parameter change: L=3, 5 samples, then param_wen with L=1, then samples 10,11 -> first output 11 ((21+1)>>1); the 5 earlier samples never contribute.
- Enable drop and rst mid-block: L=2, 3 samples then avg_en=0 for 1 cycle, then 4 samples of 8 -> output 8. Repeat with rst pulsed after 3 samples -> same result, and avg_count restarts from 0.
